// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART data-path FIFOs.
package uart_fifo_pkg;

  // Default geometry used by the UART TX/RX FIFO instances
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  // Read-mode selectors for the FWFT parameter
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Pointer width including the wrap bit: index bits plus one MSB
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Storage array for sync_fifo_ctrl: one synchronous write port and one read
// port. The read port is combinational in FWFT mode and registered otherwise.
// The array itself is never reset; only the registered read word is.
module fifo_dpram
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = 4,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_clr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Synchronous write into the array
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head entry is visible as soon as the read address points at it
      logic unused_ctrl;
      assign unused_ctrl = ^{reset, rd_clr, rd_en};
      assign rd_data     = mem[rd_addr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      // Registered read: load the head on an accepted pop, hold otherwise
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_q <= '0;
        end else if (rd_clr) begin
          rd_q <= '0;
        end else if (rd_en) begin
          rd_q <= mem[rd_addr];
        end
      end
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for the UART TX/RX paths. Wrap-bit pointers
// give full-depth use; level, threshold flags and sticky error flags are all
// decoded from registered state so no input reaches a flag combinationally.
module sync_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         write_enable,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic                         read_enable,
  output logic [DATA_WIDTH-1:0]        read_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW    = ptr_width(FIFO_DEPTH);
  localparam int PTR_W = PW - 1;

  localparam logic [PTR_W:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PTR_W:0] AE_LVL = PW'(AE_THRESH);

  logic [PTR_W:0]          wr_ptr;
  logic [PTR_W:0]          rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  // Flags come straight from the registered pointers and level
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // A request is only taken when the registered flag allows it
  assign push_ok = write_enable & ~full;
  assign pop_ok  = read_enable & ~empty;

  // Pointers, level and sticky errors; flush outranks push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level <= level - 1'b1;
      end
      if (write_enable && full) begin
        overflow <= 1'b1;
      end
      if (read_enable && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PTR_W),
    .FWFT       (FWFT)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_clr  (flush),
    .wr_en   (push_ok & ~flush),
    .wr_addr (wr_ptr[PTR_W-1:0]),
    .wr_data (write_data),
    .rd_en   (pop_ok & ~flush),
    .rd_addr (rd_ptr[PTR_W-1:0]),
    .rd_data (ram_rdata)
  );

  // In FWFT mode the stale array word is masked while nothing is held
  assign read_data = (FWFT == FWFT_ON && empty) ? '0 : ram_rdata;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one registered-read and one FWFT instance share
// stimulus; a queue-based model predicts every output of both.
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic          read_enable;

  logic [DW-1:0] rd_0, rd_1;
  logic          full_0, full_1, empty_0, empty_1;
  logic          af_0, af_1, ae_0, ae_1;
  logic [4:0]    level_0, level_1;
  logic          ovf_0, ovf_1, unf_0, unf_1;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF),
                   .AE_THRESH(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .write_enable(write_enable),
    .write_data(write_data), .read_enable(read_enable), .read_data(rd_0),
    .full(full_0), .empty(empty_0), .almost_full(af_0), .almost_empty(ae_0),
    .level(level_0), .overflow(ovf_0), .underflow(unf_0));

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF),
                   .AE_THRESH(AE), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .write_enable(write_enable),
    .write_data(write_data), .read_enable(read_enable), .read_data(rd_1),
    .full(full_1), .empty(empty_1), .almost_full(af_1), .almost_empty(ae_1),
    .level(level_1), .overflow(ovf_1), .underflow(unf_1));

  // Reference model: contents as a queue, plus error flags and registered word
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_rd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            fl;
    bit            we;
    logic [DW-1:0] wd;
    bit            re;
    int            lvl;
    bit            emp;
    bit            unf;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd0 = '0;
  endtask

  task automatic model_step();
    bit was_full, was_empty;
    if (flush) begin
      model_reset();
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (write_enable && was_full) m_ovf = 1'b1;
      if (read_enable && was_empty) m_unf = 1'b1;
      if (read_enable && !was_empty) m_rd0 = q.pop_front();
      if (write_enable && !was_full) q.push_back(write_data);
    end
  endtask

  task automatic check_dut(input string tag, input bit fwft, input int lvl,
                           input bit fu, input bit em, input bit afl,
                           input bit ael, input bit ov, input bit un,
                           input int rd);
    int n;
    int exp_rd;
    n = q.size();
    if (fwft) exp_rd = (n == 0) ? 0 : int'(q[0]);
    else      exp_rd = int'(m_rd0);
    chk({tag, " level"}, lvl, n);
    chk({tag, " full"}, int'(fu), int'(n == DEPTH));
    chk({tag, " empty"}, int'(em), int'(n == 0));
    chk({tag, " almost_full"}, int'(afl), int'(n >= AF));
    chk({tag, " almost_empty"}, int'(ael), int'(n <= AE));
    chk({tag, " overflow"}, int'(ov), int'(m_ovf));
    chk({tag, " underflow"}, int'(un), int'(m_unf));
    chk({tag, " read_data"}, rd, exp_rd);
  endtask

  task automatic check_all();
    check_dut("reg", 1'b0, int'(level_0), full_0, empty_0, af_0, ae_0, ovf_0, unf_0, int'(rd_0));
    check_dut("fwft", 1'b1, int'(level_1), full_1, empty_1, af_1, ae_1, ovf_1, unf_1, int'(rd_1));
  endtask

  task automatic cycle(input bit fl, input bit we, input logic [DW-1:0] wd, input bit re);
    flush        = fl;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    flush        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int            wp;
    int            rp;

    reset        = 1'b1;
    flush        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_data   = '0;

    //           fl  we  wd     re  lvl emp unf rd0    rd1
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 1, 1'b0, 1'b1, 8'h00, 8'h11};
    tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b1, 8'h00, 8'h11};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b1, 8'h11, 8'h22};
    tbl[4] = '{1'b0, 1'b1, 8'h33, 1'b1, 1, 1'b0, 1'b1, 8'h22, 8'h33};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 8'h44, 1'b0, 1, 1'b0, 1'b0, 8'h00, 8'h44};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00, 8'h00};

    do_reset();
    chk("reset empty", int'(empty_0), 1);
    chk("reset almost_empty", int'(ae_1), 1);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].fl, tbl[i].we, tbl[i].wd, tbl[i].re);
      chk($sformatf("tbl%0d level", i), int'(level_0), tbl[i].lvl);
      chk($sformatf("tbl%0d empty", i), int'(empty_1), int'(tbl[i].emp));
      chk($sformatf("tbl%0d underflow", i), int'(unf_0), int'(tbl[i].unf));
      chk($sformatf("tbl%0d rd reg", i), int'(rd_0), int'(tbl[i].rd0));
      chk($sformatf("tbl%0d rd fwft", i), int'(rd_1), int'(tbl[i].rd1));
    end

    // Fill to full; almost_full rises on the push reaching level 12
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == AF - 2) chk("t1 af below thresh", int'(af_0), 0);
      if (i == AF - 1) chk("t1 af at thresh", int'(af_1), 1);
    end
    chk("t1 full", int'(full_0), 1);
    chk("t1 level", int'(level_1), 16);

    // Overflow, then drain in order
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("t2 overflow", int'(ovf_1), 1);
    chk("t2 level held", int'(level_0), 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2 fwft head", int'(rd_1), i);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t2 reg data", int'(rd_0), i);
    end
    chk("t2 empty", int'(empty_0), 1);

    // Underflow holds read_data; push+pop on empty takes only the push
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3 underflow", int'(unf_0), 1);
    chk("t3 rd held", int'(rd_0), 8'h0F);
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    chk("t3 level", int'(level_0), 1);
    chk("t3 fwft word", int'(rd_1), 8'h55);

    // Level 8 then 40 cycles of simultaneous push/pop
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
      chk("t4 level steady", int'(level_1), 8);
    end

    // Level 10 with overflow set, then flush with a concurrent write
    while (q.size() < DEPTH) cycle(1'b0, 1'b1, 8'hC3, 1'b0);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t5 pre level", int'(level_0), 10);
    chk("t5 pre overflow", int'(ovf_0), 1);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    chk("t5 level", int'(level_0), 0);
    chk("t5 empty", int'(empty_1), 1);
    chk("t5 overflow", int'(ovf_1), 0);
    chk("t5 almost_empty", int'(ae_0), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5 no write", int'(level_1), 0);

    // Asynchronous reset between edges during a burst
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    write_enable = 1'b1;
    write_data   = 8'h9F;
    read_enable  = 1'b0;
    @(posedge clk);
    model_step();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6 async level", int'(level_0), 0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    write_enable = 1'b0;
    check_all();

    // Randomised traffic with phases that bias towards full and empty
    for (int i = 0; i < 1500; i++) begin
      wp = ((i / 150) % 3 == 0) ? 80 : (((i / 150) % 3 == 1) ? 20 : 50);
      rp = 100 - wp;
      v  = 8'($urandom);
      cycle(($urandom % 97) == 0, ($urandom % 100) < wp, v, ($urandom % 100) < rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
